// File: rtl/pe_operand_feeder.sv
// Operand feeder for the CNN PE: buffers one window of {act, wgt} pairs and streams them.
// Optional weight hold across windows: define PE_FEEDER_WGT_HOLD_EN.
module pe_operand_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 9,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_wgt,
    input  logic              start,
`ifdef PE_FEEDER_WGT_HOLD_EN
    input  logic              wgt_reload,
`endif
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    output logic              out_clr,
    output logic              loaded,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DRN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] act_mem [DEPTH];
    logic [DATA_W-1:0] wgt_mem [DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  rd_nxt;
    logic [DRN_W-1:0]  drn_cnt;
    logic              load_fire;
    logic              wgt_wr;

    assign load_fire = (state == IDLE) && in_valid && in_ready;
    assign rd_nxt    = rd_ptr + 1'b1;

`ifdef PE_FEEDER_WGT_HOLD_EN
    logic wgt_held;
    logic reload_now;

    // A reload request at the start of an empty window writes weights from its first pair on.
    assign reload_now = wgt_reload && (state == IDLE) && (wr_ptr == '0) && !loaded;
    assign wgt_wr     = load_fire && (!wgt_held || reload_now);
`else
    assign wgt_wr     = load_fire;
`endif

    always_ff @(posedge clk) begin
        if (!rst && load_fire) begin
            act_mem[wr_ptr] <= in_act;
        end
        if (!rst && wgt_wr) begin
            wgt_mem[wr_ptr] <= in_wgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drn_cnt   <= '0;
            in_ready  <= 1'b1;
            loaded    <= 1'b0;
            busy      <= 1'b0;
            out_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            done      <= 1'b0;
`ifdef PE_FEEDER_WGT_HOLD_EN
            wgt_held  <= 1'b0;
`endif
        end else begin
            out_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        if (wr_ptr == IDX_W'(DEPTH - 1)) begin
                            wr_ptr   <= '0;
                            loaded   <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                    if (start && loaded) begin
                        state   <= CLR;
                        out_clr <= 1'b1;
                        busy    <= 1'b1;
                        rd_ptr  <= '0;
                    end
`ifdef PE_FEEDER_WGT_HOLD_EN
                    if (reload_now) begin
                        wgt_held <= 1'b0;
                    end
`endif
                end
                CLR: begin
                    state     <= STREAM;
                    out_a     <= act_mem[rd_ptr];
                    out_b     <= wgt_mem[rd_ptr];
                    out_valid <= 1'b1;
                end
                STREAM: begin
                    if (rd_ptr == IDX_W'(DEPTH - 1)) begin
                        state     <= DRAIN;
                        out_a     <= '0;
                        out_b     <= '0;
                        out_valid <= 1'b0;
                        drn_cnt   <= '0;
                        done      <= (PE_LAT == 1);
                    end else begin
                        // Operands are fetched one entry ahead so each pair leaves a register.
                        rd_ptr <= rd_nxt;
                        out_a  <= act_mem[rd_nxt];
                        out_b  <= wgt_mem[rd_nxt];
                    end
                end
                DRAIN: begin
                    if (drn_cnt == DRN_W'(PE_LAT - 1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        loaded   <= 1'b0;
                        wr_ptr   <= '0;
`ifdef PE_FEEDER_WGT_HOLD_EN
                        wgt_held <= 1'b1;
`endif
                    end else begin
                        drn_cnt <= drn_cnt + 1'b1;
                        done    <= (drn_cnt == DRN_W'(PE_LAT - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder (DEPTH=9, PE_LAT=1) with a small accumulating PE model.
module tb_pe_operand_feeder;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 9;
    localparam int PE_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_act;
    logic [DATA_W-1:0] in_wgt;
    logic              start;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_valid;
    logic              out_clr;
    logic              loaded;
    logic              busy;
    logic              done;
`ifdef PE_FEEDER_WGT_HOLD_EN
    logic              wgt_reload;
`endif

    int     checks = 0;
    int     errors = 0;
    int     ea [DEPTH];
    int     ew [DEPTH];
    longint acc;
    int     seen;

    pe_operand_feeder #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PE_LAT(PE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .start     (start),
`ifdef PE_FEEDER_WGT_HOLD_EN
        .wgt_reload(wgt_reload),
`endif
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_clr   (out_clr),
        .loaded    (loaded),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int a, input int w);
        check("load_rdy", longint'(in_ready), 1);
        in_valid = 1'b1;
        in_act   = a;
        in_wgt   = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fill(input int a, input int w);
        for (int i = 0; i < DEPTH; i++) begin
            load(a, w);
            ea[i] = a;
            ew[i] = w;
        end
    endtask

    task automatic run_window(input longint exp_sum);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr", longint'(out_clr), 1);
        check("clr_valid", longint'(out_valid), 0);
        check("clr_busy", longint'(busy), 1);
        check("clr_a", longint'(out_a), 0);
        acc = 0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check("s_valid", longint'(out_valid), 1);
            check("s_a", longint'(out_a), longint'(ea[k]));
            check("s_b", longint'(out_b), longint'(ew[k]));
            check("s_rdy", longint'(in_ready), 0);
            check("s_done", longint'(done), 0);
            if (out_valid) acc += longint'(out_a) * longint'(out_b);
        end
        tick();
        in_valid = 1'b0;
        check("drn_valid", longint'(out_valid), 0);
        check("drn_a", longint'(out_a), 0);
        check("drn_b", longint'(out_b), 0);
        check("done", longint'(done), 1);
        check("acc", acc, exp_sum);
        tick();
        check("post_done", longint'(done), 0);
        check("post_busy", longint'(busy), 0);
        check("post_rdy", longint'(in_ready), 1);
        check("post_loaded", longint'(loaded), 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        in_act   = '0;
        in_wgt   = '0;
`ifdef PE_FEEDER_WGT_HOLD_EN
        wgt_reload = 1'b0;
`endif
        tick();
        tick();
        check("rst_rdy", longint'(in_ready), 1);
        check("rst_loaded", longint'(loaded), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_clr", longint'(out_clr), 0);
        check("rst_done", longint'(done), 0);
        check("rst_a", longint'(out_a), 0);
        check("rst_b", longint'(out_b), 0);
        rst = 1'b0;

        // Basic window: acts 1..9, weights 2 -> 90.
        for (int i = 0; i < DEPTH; i++) begin
            load(i + 1, 2);
            ea[i] = i + 1;
            ew[i] = 2;
        end
        check("full_loaded", longint'(loaded), 1);
        check("full_rdy", longint'(in_ready), 0);
        run_window(90);

        // Early start after 5 loads, then start coincident with the final load.
        for (int i = 0; i < 5; i++) load(i + 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("early_busy", longint'(busy), 0);
        check("early_clr", longint'(out_clr), 0);
        check("early_valid", longint'(out_valid), 0);
        check("early_loaded", longint'(loaded), 0);
        check("early_rdy", longint'(in_ready), 1);
        for (int i = 5; i < DEPTH - 1; i++) load(i + 1, 1);
        check("last_rdy", longint'(in_ready), 1);
        in_valid = 1'b1;
        in_act   = 9;
        in_wgt   = 1;
        start    = 1'b1;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        check("same_busy", longint'(busy), 0);
        check("same_clr", longint'(out_clr), 0);
        check("same_loaded", longint'(loaded), 1);
        tick();
        check("same_busy2", longint'(busy), 0);
        for (int i = 0; i < DEPTH; i++) begin
            ea[i] = i + 1;
            ew[i] = 1;
        end

        // in_valid held with junk data while streaming must not be consumed.
        in_valid = 1'b1;
        in_act   = 99;
        in_wgt   = 99;
        run_window(45);

        // Back-to-back windows.
        fill(1, 3);
        run_window(27);
        fill(2, 1);
        run_window(18);

        // Reset on the 4th streamed pair.
        fill(5, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_valid", longint'(out_valid), 1);
        check("mid_a", longint'(out_a), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", longint'(out_valid), 0);
        check("abort_a", longint'(out_a), 0);
        check("abort_b", longint'(out_b), 0);
        check("abort_rdy", longint'(in_ready), 1);
        check("abort_loaded", longint'(loaded), 0);
        check("abort_busy", longint'(busy), 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) seen++;
            tick();
        end
        check("abort_nodone", longint'(seen), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_start", longint'(busy), 0);
        fill(3, 1);
        run_window(27);

`ifdef PE_FEEDER_WGT_HOLD_EN
        // Weights held across windows until wgt_reload.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill(1, 3);
        run_window(27);
        fill(1, 7);
        for (int i = 0; i < DEPTH; i++) ew[i] = 3;
        run_window(27);
        wgt_reload = 1'b1;
        tick();
        wgt_reload = 1'b0;
        fill(1, 7);
        run_window(63);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Upstream stage of the CNN processing element.
- Buffers one convolution window of activation/weight pairs, supplied through a valid/ready load port.
- Streams the buffered pairs to the PE operand inputs (A, B), one pair per cycle, then waits out the PE latency and signals done.
- Drives zero operands whenever it is not streaming, so an accumulating PE adds nothing outside a window.

Parameters:
- DATA_W, 32, width of each activation and weight word; matches the PE operand width.
- DEPTH, 9, pairs per window (3x3 kernel); legal range 1..16.
- PE_LAT, 1, PE result latency in cycles, covered by the DRAIN state; legal range 1..8.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  load pair valid
- in_ready  output  1  feeder accepts a load pair this cycle
- in_act  input  DATA_W  activation word
- in_wgt  input  DATA_W  weight word
- start  input  1  begin streaming a loaded window (single-cycle pulse)
- out_a  output  DATA_W  operand to PE input A (activation)
- out_b  output  DATA_W  operand to PE input B (weight)
- out_valid  output  1  out_a/out_b carry a live pair
- out_clr  output  1  one-cycle pulse on the cycle before the first streamed pair (accumulator clear)
- loaded  output  1  a full window is buffered
- busy  output  1  state is CLR, STREAM or DRAIN
- done  output  1  one-cycle pulse, PE result for the window is valid at the PE output

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; write/read pointers and counters 0.
  - All outputs 0 except in_ready=1.
  - Buffer contents are don't-care.
- Buffer: DEPTH entries of {act, wgt}, registered.
- States and transitions:
  - IDLE:
    - in_ready=1 while wr_ptr<DEPTH.
    - Each in_valid&in_ready stores the pair at wr_ptr, then wr_ptr++.
    - When wr_ptr reaches DEPTH: loaded=1, in_ready=0.
    - start with loaded=1 -> CLR.
    - start with loaded=0 is ignored. No error and no state change.
  - CLR (1 cycle): out_clr=1, operands 0, out_valid=0. Next state is STREAM with rd_ptr=0.
  - STREAM (exactly DEPTH cycles):
    - out_a/out_b = buffer[rd_ptr], registered from the buffer; out_valid=1.
    - rd_ptr++ each cycle.
    - After entry DEPTH-1 -> DRAIN.
  - DRAIN (exactly PE_LAT cycles): operands 0, out_valid=0.
    - On the last drain cycle: done=1, wr_ptr=0, loaded=0, next state IDLE.
    - in_ready returns to 1 in IDLE.
- Latency: start accepted at cycle t gives:
  - out_clr at t+1;
  - first pair at t+2;
  - last pair at t+1+DEPTH;
  - done at t+1+DEPTH+PE_LAT.
- Loading is blocked (in_ready=0) during CLR/STREAM/DRAIN. No overlap of load and stream.
- start while busy is ignored.
- in_valid with in_ready=0 is not consumed. The upstream must hold its data.
- Simultaneous final load handshake and start in the same cycle: the start is ignored, because loaded is still 0 in that cycle.
- out_a/out_b = 0 whenever out_valid=0.
- rst mid-stream or mid-drain aborts the window immediately:
  - no done pulse;
  - buffer is treated as empty.

Optional Feature:
- Macro: PE_FEEDER_WGT_HOLD_EN.
- With the macro defined, weights are kept across windows:
  - After the first complete window, the load port writes activations only; in_wgt is ignored.
  - DEPTH activation handshakes set loaded=1.
  - An extra input wgt_reload (1 bit) forces the next window to load full pairs again. It is sampled in IDLE while wr_ptr=0.
  - rst clears the held-weight flag.
- Without the macro: every window loads full pairs, and the wgt_reload port does not exist.

Test Plan:
- DEPTH=9, PE_LAT=1; load pairs act=i+1, wgt=2 for i=0..8, then pulse start.
  - out_clr one cycle after start.
  - Pairs (1,2)..(9,2) on consecutive cycles.
  - done at start+11.
  - The PE accumulates 90.
- start pulsed after only 5 of 9 loads -> no state change, busy=0, out_valid=0; completing the loads then sets loaded=1.
- in_valid held high during STREAM -> in_ready=0 and no buffer write. The next window streams only the data loaded after done.
- rst asserted on the 4th STREAM cycle -> the next cycle shows out_valid=0, out_a=out_b=0, in_ready=1, loaded=0, and no done pulse.
- Back-to-back windows (act all 1 with wgt all 3, then act all 2 with wgt all 1) -> two done pulses; the PE results are 27 and 18.
- PE_FEEDER_WGT_HOLD_EN: window 1 loads pairs with wgt=3; window 2 loads act=1 with in_wgt=7 -> streamed out_b=3 in window 2. Asserting wgt_reload before window 3 -> out_b=7.
